// File: rtl/spi_flash_read_ctrl_pkg.sv
// Shared constants for the SPI flash read initiator: opcodes, address width, FSM encodings.
package spi_flash_read_ctrl_pkg;

  localparam int ADDR_W = 24;

  localparam logic [7:0] OP_READ = 8'h03;
  localparam logic [7:0] OP_WAKE = 8'hAB;

  typedef logic [2:0] state_t;

  localparam state_t ST_IDLE = 3'd0;
  localparam state_t ST_WAKE = 3'd1;
  localparam state_t ST_WGAP = 3'd2;
  localparam state_t ST_CMD  = 3'd3;
  localparam state_t ST_ADDR = 3'd4;
  localparam state_t ST_DATA = 3'd5;
  localparam state_t ST_HOLD = 3'd6;
  localparam state_t ST_END  = 3'd7;

  // States in which SCK is allowed to toggle
  function automatic logic sck_active(input state_t s);
    return (s == ST_WAKE) || (s == ST_CMD) || (s == ST_ADDR) || (s == ST_DATA);
  endfunction

endpackage

// File: rtl/spi_flash_read_ctrl_sck_divider.sv
// SCK generator: each phase lasts CLK_DIV clocks; strobes flag the edge where SCK rises/falls.
module spi_sck_divider #(
  parameter int CLK_DIV = 2
) (
  input  logic clock,
  input  logic resetb,
  input  logic en,
  output logic sck,
  output logic rise,
  output logic fall
);

  localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  logic [CW-1:0] cnt;
  logic          tick;

  assign tick = en && (cnt == CW'(CLK_DIV - 1));
  assign rise = tick && !sck;
  assign fall = tick && sck;

  // Dropping en parks SCK low and restarts a full low phase on re-enable
  always_ff @(posedge clock or negedge resetb) begin
    if (!resetb) begin
      cnt <= '0;
      sck <= 1'b0;
    end else if (!en) begin
      cnt <= '0;
      sck <= 1'b0;
    end else if (tick) begin
      cnt <= '0;
      sck <= ~sck;
    end else begin
      cnt <= cnt + CW'(1);
    end
  end

endmodule

// File: rtl/spi_flash_read_ctrl.sv
// SPI mode-0 flash reader: optional 0xAB wake, then READ 0x03 + 24-bit address, bytes out over valid/ready.
module spi_flash_read_ctrl
  import spi_flash_read_ctrl_pkg::*;
#(
  parameter int CLK_DIV     = 2,
  parameter int WAKE_EN     = 1,
  parameter int WAKE_GAP    = 8,
  parameter int CS_HIGH_MIN = 4,
  parameter int LEN_W       = 16
) (
  input  logic              clock,
  input  logic              resetb,
  input  logic              start,
  input  logic [ADDR_W-1:0] start_addr,
  input  logic [LEN_W-1:0]  byte_count,
  input  logic              abort,
  output logic              busy,
  output logic              done,
  output logic [7:0]        rd_data,
  output logic              rd_valid,
  input  logic              rd_ready,
  output logic              flash_csb,
  output logic              flash_clk,
  output logic              flash_io0,
  input  logic              flash_io1
);

  state_t            state;
  logic              wake_done;
  logic [31:0]       tx;
  logic [6:0]        rx;
  logic [4:0]        bit_cnt;
  logic [LEN_W-1:0]  remain;
  logic [ADDR_W-1:0] addr_q;
  logic [15:0]       gap_cnt;
  logic              sck_en, sck_rise, sck_fall;
  logic              pend_next;
  logic              do_abort;

  assign do_abort  = abort && (state != ST_IDLE) && (state != ST_END);
  assign sck_en    = sck_active(state) && !abort;
  assign pend_next = rd_valid && !rd_ready;
  assign flash_io0 = tx[31];

  spi_sck_divider #(.CLK_DIV(CLK_DIV)) u_sck (
    .clock (clock),
    .resetb(resetb),
    .en    (sck_en),
    .sck   (flash_clk),
    .rise  (sck_rise),
    .fall  (sck_fall)
  );

  always_ff @(posedge clock or negedge resetb) begin
    if (!resetb) begin
      state     <= ST_IDLE;
      wake_done <= 1'b0;
      tx        <= '0;
      rx        <= '0;
      bit_cnt   <= '0;
      remain    <= '0;
      addr_q    <= '0;
      gap_cnt   <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      rd_data   <= '0;
      rd_valid  <= 1'b0;
      flash_csb <= 1'b1;
    end else begin
      done <= 1'b0;
      if (rd_valid && rd_ready) rd_valid <= 1'b0;
      // MOSI only moves while SCK goes low; MISO captured as SCK goes high
      if (sck_fall) tx <= {tx[30:0], 1'b0};
      if (sck_rise) rx <= {rx[5:0], flash_io1};

      case (state)
        ST_IDLE: if (start) begin
          if (byte_count == '0) begin
            done <= 1'b1;
          end else begin
            busy      <= 1'b1;
            remain    <= byte_count;
            addr_q    <= start_addr;
            bit_cnt   <= '0;
            flash_csb <= 1'b0;
            if (WAKE_EN != 0 && !wake_done) begin
              state <= ST_WAKE;
              tx    <= {OP_WAKE, 24'h0};
            end else begin
              state <= ST_CMD;
              tx    <= {OP_READ, start_addr};
            end
          end
        end
        ST_WAKE: begin
          if (sck_rise) bit_cnt <= bit_cnt + 5'd1;
          else if (sck_fall && bit_cnt == 5'd8) begin
            state     <= ST_WGAP;
            flash_csb <= 1'b1;
            wake_done <= 1'b1;
            gap_cnt   <= '0;
          end
        end
        ST_WGAP: begin
          if (gap_cnt == 16'(WAKE_GAP - 1)) begin
            state     <= ST_CMD;
            tx        <= {OP_READ, addr_q};
            bit_cnt   <= '0;
            flash_csb <= 1'b0;
          end else begin
            gap_cnt <= gap_cnt + 16'd1;
          end
        end
        ST_CMD: if (sck_rise) begin
          if (bit_cnt == 5'd7) begin
            state   <= ST_ADDR;
            bit_cnt <= '0;
          end else bit_cnt <= bit_cnt + 5'd1;
        end
        ST_ADDR: if (sck_rise) begin
          if (bit_cnt == 5'd23) begin
            state   <= ST_DATA;
            bit_cnt <= '0;
          end else bit_cnt <= bit_cnt + 5'd1;
        end
        ST_DATA: begin
          if (sck_rise) begin
            bit_cnt <= bit_cnt + 5'd1;
            if (bit_cnt == 5'd7) begin
              rd_data  <= {rx, flash_io1};
              rd_valid <= 1'b1;
              remain   <= remain - LEN_W'(1);
            end
          end else if (sck_fall && bit_cnt == 5'd8) begin
            // Byte boundary: stall SCK here if the previous byte is still unclaimed
            bit_cnt <= '0;
            if (pend_next) begin
              state <= ST_HOLD;
            end else if (remain == '0) begin
              state     <= ST_END;
              flash_csb <= 1'b1;
              gap_cnt   <= '0;
            end
          end
        end
        ST_HOLD: if (!pend_next) begin
          if (remain == '0) begin
            state     <= ST_END;
            flash_csb <= 1'b1;
            gap_cnt   <= '0;
          end else begin
            state <= ST_DATA;
          end
        end
        ST_END: begin
          if (gap_cnt == 16'(CS_HIGH_MIN - 1)) begin
            state <= ST_IDLE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end else begin
            gap_cnt <= gap_cnt + 16'd1;
          end
        end
        default: state <= ST_IDLE;
      endcase

      // Abort overrides everything above; a pending byte is dropped as if taken
      if (do_abort) begin
        state     <= ST_END;
        flash_csb <= 1'b1;
        tx        <= '0;
        rd_valid  <= 1'b0;
        gap_cnt   <= '0;
        bit_cnt   <= '0;
      end
    end
  end

endmodule

// File: tb/tb_spi_flash_read_ctrl.sv
// Directed bench for spi_flash_read_ctrl with a small behavioural serial-flash model.
module tb_spi_flash_read_ctrl;

  logic        clock = 1'b0;
  logic        resetb;
  logic        start, abort, rd_ready;
  logic [23:0] start_addr;
  logic [15:0] byte_count;
  logic        busy, done, rd_valid;
  logic [7:0]  rd_data;
  logic        flash_csb, flash_clk, flash_io0, flash_io1;

  always #5 clock = ~clock;

  spi_flash_read_ctrl #(
    .CLK_DIV(2), .WAKE_EN(1), .WAKE_GAP(8), .CS_HIGH_MIN(4), .LEN_W(16)
  ) dut (
    .clock(clock), .resetb(resetb), .start(start), .start_addr(start_addr),
    .byte_count(byte_count), .abort(abort), .busy(busy), .done(done),
    .rd_data(rd_data), .rd_valid(rd_valid), .rd_ready(rd_ready),
    .flash_csb(flash_csb), .flash_clk(flash_clk), .flash_io0(flash_io0),
    .flash_io1(flash_io1)
  );

  // Flash model: content mem[i] = 0x5A + 3*i
  logic [7:0]  mem [256];
  int          bitn = 0;
  int          wake_cnt = 0;
  int          csb_falls = 0;
  int          done_cnt = 0;
  int          kbit;
  logic [7:0]  mcmd = '0;
  logic [23:0] maddr = '0;
  logic [7:0]  midx;
  logic        miso = 1'b0;
  logic [7:0]  cmds [$];
  logic [7:0]  got [$];

  assign flash_io1 = miso;

  always @(negedge flash_csb or posedge flash_clk) begin
    if (!flash_clk) begin
      bitn = 0;
    end else if (!flash_csb) begin
      bitn++;
      if (bitn <= 8) mcmd = {mcmd[6:0], flash_io0};
      if (bitn == 8) begin
        cmds.push_back(mcmd);
        if (mcmd == 8'hAB) wake_cnt++;
      end
      if (bitn > 8 && bitn <= 32) maddr = {maddr[22:0], flash_io0};
    end
  end

  always @(negedge flash_clk) begin
    if (!flash_csb && bitn >= 32 && mcmd == 8'h03) begin
      kbit = bitn - 32;
      midx = maddr[7:0] + 8'(kbit / 8);
      miso = mem[midx][3'(7 - (kbit % 8))];
    end
  end

  always @(negedge flash_csb) csb_falls++;

  always @(negedge clock) begin
    if (rd_valid && rd_ready) got.push_back(rd_data);
    if (done) done_cnt++;
  end

  int n_chk = 0;
  int n_fail = 0;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", tag, act, exp);
    end
  endtask

  task automatic chk_bytes(input string tag, input int n,
                           input logic [7:0] e0, e1, e2, e3);
    logic [7:0] e [4];
    e = '{e0, e1, e2, e3};
    chk({tag, "_n"}, got.size(), n);
    for (int i = 0; i < n; i++)
      chk($sformatf("%s_b%0d", tag, i),
          (got.size() > i) ? {24'h0, got[i]} : 32'hFFFF_FFFF, {24'h0, e[i]});
  endtask

  task automatic do_start(input logic [23:0] a, input logic [15:0] n);
    @(posedge clock); #1;
    start = 1'b1; start_addr = a; byte_count = n;
    @(posedge clock); #1;
    start = 1'b0;
  endtask

  task automatic wait_done(input string tag);
    int n;
    n = 0;
    @(negedge clock);
    while (!done && n < 4000) begin
      @(negedge clock);
      n++;
    end
    chk({tag, "_done"}, done, 1'b1);
    chk({tag, "_busy_at_done"}, busy, 1'b0);
  endtask

  task automatic wait_bit(input int target);
    int n;
    n = 0;
    while (bitn < target && n < 2000) begin
      @(negedge clock);
      n++;
    end
    chk($sformatf("reach_bit%0d", target), (bitn >= target), 1'b1);
  endtask

  int c0, d0, w0, viol, n;

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 8'(8'h5A + 3 * i);
    resetb = 1'b0; start = 1'b0; abort = 1'b0; rd_ready = 1'b1;
    start_addr = '0; byte_count = '0;
    #23;
    chk("rst_csb", flash_csb, 1'b1);
    chk("rst_clk", flash_clk, 1'b0);
    chk("rst_io0", flash_io0, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_done", done, 1'b0);
    chk("rst_valid", rd_valid, 1'b0);
    chk("rst_data", rd_data, 8'h00);
    @(posedge clock); #1 resetb = 1'b1;

    // 1: first read sends wake then READ 0x000000
    got.delete(); c0 = csb_falls; d0 = done_cnt;
    do_start(24'h000000, 16'd4);
    chk("t1_busy", busy, 1'b1);
    chk("t1_csb_low", flash_csb, 1'b0);
    wait_done("t1");
    repeat (6) @(negedge clock);
    chk("t1_wake_cnt", wake_cnt, 1);
    chk("t1_cmd0", cmds.size() > 0 ? cmds[0] : 8'h00, 8'hAB);
    chk("t1_cmd1", cmds.size() > 1 ? cmds[1] : 8'h00, 8'h03);
    chk("t1_addr", maddr, 24'h000000);
    chk("t1_csb_falls", csb_falls - c0, 2);
    chk("t1_done_cnt", done_cnt - d0, 1);
    chk_bytes("t1", 4, 8'h5A, 8'h5D, 8'h60, 8'h63);

    // 2: no wake on later reads, one CSB-low period
    got.delete(); c0 = csb_falls; d0 = done_cnt;
    do_start(24'h000010, 16'd2);
    wait_done("t2");
    repeat (6) @(negedge clock);
    chk("t2_wake_cnt", wake_cnt, 1);
    chk("t2_addr", maddr, 24'h000010);
    chk("t2_csb_falls", csb_falls - c0, 1);
    chk("t2_done_cnt", done_cnt - d0, 1);
    chk_bytes("t2", 2, 8'h8A, 8'h8D, 8'h00, 8'h00);

    // 3: backpressure after byte 0 parks SCK low with CSB held
    got.delete(); c0 = csb_falls; d0 = done_cnt;
    do_start(24'h000020, 16'd3);
    n = 0;
    while (got.size() < 1 && n < 2000) begin @(negedge clock); n++; end
    @(posedge clock); #1 rd_ready = 1'b0;
    n = 0;
    while (!rd_valid && n < 200) begin @(negedge clock); n++; end
    chk("t3_valid", rd_valid, 1'b1);
    repeat (4) @(negedge clock);
    viol = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clock);
      if (flash_clk !== 1'b0 || flash_csb !== 1'b0 || rd_valid !== 1'b1) viol++;
    end
    chk("t3_flat", viol, 0);
    chk("t3_held_data", rd_data, 8'hBD);
    @(posedge clock); #1 rd_ready = 1'b1;
    wait_done("t3");
    repeat (6) @(negedge clock);
    chk("t3_csb_falls", csb_falls - c0, 1);
    chk("t3_done_cnt", done_cnt - d0, 1);
    chk_bytes("t3", 3, 8'hBA, 8'hBD, 8'hC0, 8'h00);

    // 4: zero length completes with no flash activity
    c0 = csb_falls; d0 = done_cnt;
    do_start(24'h000050, 16'd0);
    chk("t4_done", done, 1'b1);
    chk("t4_busy", busy, 1'b0);
    repeat (10) @(negedge clock);
    chk("t4_csb_falls", csb_falls - c0, 0);
    chk("t4_done_cnt", done_cnt - d0, 1);

    // 5: abort at bit 5 of byte 1
    got.delete(); d0 = done_cnt;
    do_start(24'h000040, 16'd8);
    wait_bit(45);
    @(posedge clock); #1 abort = 1'b1;
    @(posedge clock); #1 abort = 1'b0;
    @(negedge clock);
    chk("t5_csb", flash_csb, 1'b1);
    chk("t5_clk", flash_clk, 1'b0);
    chk("t5_valid", rd_valid, 1'b0);
    wait_done("t5");
    repeat (6) @(negedge clock);
    chk("t5_done_cnt", done_cnt - d0, 1);
    chk_bytes("t5", 1, 8'h1A, 8'h00, 8'h00, 8'h00);
    got.delete();
    do_start(24'h000008, 16'd2);
    wait_done("t5r");
    repeat (6) @(negedge clock);
    chk("t5r_wake_cnt", wake_cnt, 1);
    chk_bytes("t5r", 2, 8'h72, 8'h75, 8'h00, 8'h00);

    // 6: async reset mid-address, next read re-sends wake
    do_start(24'h000030, 16'd1);
    wait_bit(12);
    @(negedge clock); #2 resetb = 1'b0;
    #1;
    chk("t6_csb", flash_csb, 1'b1);
    chk("t6_clk", flash_clk, 1'b0);
    chk("t6_io0", flash_io0, 1'b0);
    chk("t6_busy", busy, 1'b0);
    @(posedge clock); #1 resetb = 1'b1;
    got.delete(); w0 = wake_cnt;
    do_start(24'h000030, 16'd1);
    wait_done("t6");
    repeat (6) @(negedge clock);
    chk("t6_wake_cnt", wake_cnt - w0, 1);
    chk("t6_addr", maddr, 24'h000030);
    chk_bytes("t6", 1, 8'hEA, 8'h00, 8'h00, 8'h00);

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule
